// File: rtl/const_divider_seq.sv
// rtl/const_divider_seq.sv - restoring radix-2 divider by a fixed constant N, one quotient bit per clock
// Optional range check output enabled by defining CONST_DIV_CHECK_EN.
module const_divider_seq #(
    parameter int          J = 6,
    parameter int unsigned N = 119
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*J+1:0] dividend,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*J+1:0] quotient,
    output logic [J:0]     remainder
`ifdef CONST_DIV_CHECK_EN
    ,
    output logic           range_err
`endif
);

    localparam int          W  = 2 * J + 2;
    localparam int          CW = $clog2(W);
    localparam logic [J+1:0] NP = (J + 2)'(N);

    // The divisor must be nonzero and fit the operand width.
    generate
        if (N == 0 || N >= (1 << (J + 1))) begin : g_bad_n
            $error("const_divider_seq: N must be nonzero and fit in J+1 bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_dsh;
    logic [J+1:0]    r_pr;
    logic [W-1:0]    r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [W-1:0]    r_quotient;
    logic [J:0]      r_remainder;
    logic            r_range_err;

    logic [J+1:0]    w_pr_shift;
    logic            w_ge;
    logic [J+1:0]    w_pr_next;
    logic [W-1:0]    w_q_next;

    // One restoring step: bring in the next dividend bit, subtract N when it fits.
    always_comb begin
        w_pr_shift = {r_pr[J:0], r_dsh[W-1]};
        w_ge       = (w_pr_shift >= NP);
        w_pr_next  = w_ge ? (w_pr_shift - NP) : w_pr_shift;
        w_q_next   = {r_q[W-2:0], w_ge};
    end

    // Control FSM and datapath registers; results are captured on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dsh       <= '0;
            r_pr        <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_range_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dsh   <= dividend;
                        r_pr    <= '0;
                        r_q     <= '0;
                        r_cnt   <= CW'(W - 1);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_pr  <= w_pr_next;
                    r_dsh <= {r_dsh[W-2:0], 1'b0};
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_pr_next[J:0];
                        // A valid product of N and a (J+1)-bit operand has no high quotient bits.
                        r_range_err <= |w_q_next[W-1:J+1];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_range_err <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

`ifdef CONST_DIV_CHECK_EN
    assign range_err = r_range_err;
`else
    logic w_unused_range;
    assign w_unused_range = r_range_err;
`endif

endmodule

// File: tb/tb_const_divider_seq.sv
// tb/tb_const_divider_seq.sv - directed and randomized checks of const_divider_seq (N=119, J=6)
module tb_const_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] dividend;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] quotient;
    logic [6:0]  remainder;
`ifdef CONST_DIV_CHECK_EN
    logic        range_err;
`endif

    int total = 0;
    int bad   = 0;

    const_divider_seq #(.J(6), .N(119)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef CONST_DIV_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Latency is counted in rising edges including the accept edge.
    task automatic run_div(input logic [13:0] d, input logic [13:0] eq, input logic [6:0] er,
                           input logic ee, input int hold, input string tag);
        int w;
        int cnt;
        logic [13:0] q0;
        logic [6:0]  r0;
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = d;
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 14'h3fff;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd15);
        chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef CONST_DIV_CHECK_EN
        chk({tag, "_range_err"}, 32'(range_err), 32'(ee));
`else
        if (ee === 1'bx) chk({tag, "_range_x"}, 32'd0, 32'd1);
`endif
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            dividend = 14'd238;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_q"}, 32'(quotient), 32'(q0));
            chk({tag, "_hold_r"}, 32'(remainder), 32'(r0));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int gap;
        logic [13:0] d;
        logic [13:0] gq;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
`ifdef CONST_DIV_CHECK_EN
        chk("reset_range_err", 32'(range_err), 32'd0);
`endif
        rst = 1'b0;

        run_div(14'd10353, 14'd87,  7'd0,  1'b0, 0, "exact_87");
        run_div(14'd10400, 14'd87,  7'd47, 1'b0, 0, "rem_47");
        run_div(14'd0,     14'd0,   7'd0,  1'b0, 0, "zero");
        run_div(14'd16383, 14'd137, 7'd80, 1'b1, 0, "max");
        run_div(14'd15113, 14'd127, 7'd0,  1'b0, 0, "exact_127");
        run_div(14'd10400, 14'd87,  7'd47, 1'b0, 5, "stall5");

        // Abort a division partway through CALC with reset.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 14'd16383;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        run_div(14'd238, 14'd2, 7'd0, 1'b0, 0, "after_abort");

        // Randomized sweep against the golden div/mod model.
        for (int k = 0; k < 2000; k++) begin
            d   = 14'($urandom_range(0, 16383));
            gq  = d / 14'd119;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_div(d, gq, 7'(d % 14'd119), (gq > 14'd127), $urandom_range(0, 2), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
